uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clocks per bit period (legal 8..1023).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 Parameter PARITY, default 0, 0=none, 1=odd, 2=even.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rx  input  1  asynchronous serial line, idle high, LSB first.
REQ-008 data  output  DATA_BITS  received word, stable while valid=1.
REQ-009 valid  output  1  word available in holding register.
REQ-010 ready  input  1  consumer accepts word when valid&ready.
REQ-011 parity_err  output  1  parity mismatch for held word, qualified by valid.
REQ-012 frame_err  output  1  stop bit sampled low for held word, qualified by valid.
REQ-013 overrun  output  1  one-cycle pulse: completed frame dropped because holding register full.
REQ-014 break_det  output  1  one-cycle pulse: line low for entire frame incl. stop bit(s).

Function
REQ-015 rx SHALL pass a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized signal rx_s.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-017 IDLE: on rx_s=0, bit counter SHALL clear to 0 and state SHALL move to START.
REQ-018 Bit counter SHALL count 0..CLKS_PER_BIT-1 per bit, wrapping to 0 and advancing bit index on terminal count.
REQ-019 Each bit value SHALL be the 2-of-3 majority of rx_s sampled at counts MID-1, MID, MID+1, MID=(CLKS_PER_BIT-1)/2.
REQ-020 START: if start majority =1 at MID+1, state SHALL return to IDLE (false start, no outputs asserted).
REQ-021 DATA: DATA_BITS bits SHALL be shifted in LSB first; then PARITY (if enabled) else STOP.
REQ-022 Parity: odd requires XOR(data,parity bit)=1, even requires =0; mismatch sets parity_err for that word.
REQ-023 STOP: STOP_BITS bits sampled; any low stop sample sets frame_err for that word.
REQ-024 Frame completion SHALL occur at MID+1 of the last stop bit (not end of bit period); state returns to IDLE same cycle, permitting back-to-back frames.
REQ-025 Break: if all data bits, parity bit and stop bits sampled 0, break_det SHALL pulse 1 cycle at completion and no word SHALL be loaded.
REQ-026 On completion (non-break) with valid=0 or (valid&ready) that cycle, data/parity_err/frame_err SHALL load and valid SHALL be 1 next cycle.
REQ-027 On completion with valid=1 and ready=0, new word SHALL be discarded, held word unchanged, overrun pulses 1 cycle.
REQ-028 valid SHALL clear the cycle after valid&ready unless a new word loads that same cycle (REQ-026).
REQ-029 data, parity_err, frame_err SHALL not change while valid=1 and ready=0.
REQ-030 Latency: valid rises 1 cycle after completion cycle.
REQ-031 Counter widths SHALL derive from $clog2 of parameters; no overflow at legal extremes.

Reset
REQ-032 While rst=1: state=IDLE, counters 0, data=0, valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0, synchronizer flops=1.
REQ-033 rst asserted mid-frame SHALL abort the frame; partially received bits SHALL never appear on data.
REQ-034 After rst deasserts, a line already low SHALL be treated as a start bit only after the synchronizer output reads 0.

Verification (bench CLKS_PER_BIT=16 unless stated)
REQ-035 8N1, ready=1, send 0xA5 -> valid 1 cycle, data=0xA5, parity_err=0, frame_err=0.
REQ-036 PARITY=2 (even), send 0x03 with parity bit 1 -> data=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-037 ready=0, send 0x11 then 0x22 back-to-back -> data holds 0x11, overrun pulses once at second completion; raise ready -> valid drops next cycle.
REQ-038 Send 0x55 with stop bit low (not break) -> data=0x55, frame_err=1; hold rx low 12 bit times -> break_det pulse, valid stays 0.
REQ-039 Start-bit glitch 3 cycles low -> no valid, state IDLE; single-cycle glitch at MID inside data bit 2 of 0x00 -> data=0x00 (majority).
REQ-040 Assert rst during bit 4 of 0xFF, release, send 0x3C -> only data=0x3C observed; DATA_BITS=9, STOP_BITS=2 send 0x1AB -> data=0x1AB.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle of uart_rx_cfg: held word, its error flags,
// the consumer's ready, and the overrun/break event pulses.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 break_det;

  modport master (
    output data, valid, parity_err, frame_err, overrun, break_det,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun, break_det,
    output ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority voting at mid-bit, optional
// parity, 1/2 stop bits, one-word holding register with overrun/break pulses.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  uart_rx_cfg_if.master     bus
);

  localparam int MID   = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_M1    = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] MID_0     = CNT_W'(MID);
  localparam logic [CNT_W-1:0] MID_P1    = CNT_W'(MID + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 arm_q, arm_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 zero_q, zero_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 brk_q, brk_d;

  logic maj, cnt_tc, at_p1, par_x;
  logic done, frame_brk, frame_ferr, frame_perr;

  assign maj    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
  assign cnt_tc = (cnt_q == CNT_LAST);
  assign at_p1  = (cnt_q == MID_P1);
  assign par_x  = (^shift_q) ^ par_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    arm_d      = arm_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    zero_d     = zero_q;
    done       = 1'b0;
    frame_brk  = 1'b0;
    frame_ferr = 1'b0;
    frame_perr = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;

    if (state_q != S_IDLE) cnt_d = cnt_tc ? '0 : cnt_q + 1'b1;
    if (cnt_q == MID_M1) vote_d[0] = rx_s_q;
    if (cnt_q == MID_0)  vote_d[1] = rx_s_q;

    unique case (state_q)
      S_IDLE: begin
        // After a break the line must return high before a new start is accepted
        if (rx_s_q) arm_d = 1'b1;
        if (!rx_s_q && arm_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (at_p1 && maj) begin
          state_d = S_IDLE;
        end else if (cnt_tc) begin
          state_d    = S_DATA;
          idx_d      = '0;
          ferr_acc_d = 1'b0;
          zero_d     = 1'b1;
        end
      end
      S_DATA: begin
        if (at_p1) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (maj) zero_d = 1'b0;
        end
        if (cnt_tc) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (at_p1) begin
          par_d = maj;
          if (maj) zero_d = 1'b0;
        end
        if (cnt_tc) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_p1) begin
          ferr_acc_d = ferr_acc_q | ~maj;
          zero_d     = zero_q & ~maj;
          // Frame completes mid-way through the last stop bit so a following start edge is not missed
          if (idx_q == STOP_LAST) begin
            done       = 1'b1;
            frame_brk  = zero_q & ~maj;
            frame_ferr = ferr_acc_q | ~maj;
            state_d    = S_IDLE;
            cnt_d      = '0;
            if (zero_q && !maj) arm_d = 1'b0;
          end
        end else if (cnt_tc) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    brk_d     = 1'b0;
    if (valid_q && bus.ready) valid_d = 1'b0;
    if (done && frame_brk) begin
      brk_d = 1'b1;
    end else if (done) begin
      if (!valid_q || bus.ready) begin
        data_d  = shift_q;
        perr_d  = frame_perr;
        ferr_d  = frame_ferr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      arm_q     <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      arm_q     <= arm_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      brk_q     <= brk_d;
    end
  end

  // Sample/shift datapath is fully rewritten within every frame before use
  always_ff @(posedge clk) begin
    vote_q     <= vote_d;
    shift_q    <= shift_d;
    par_q      <= par_d;
    ferr_acc_q <= ferr_acc_d;
    zero_q     <= zero_d;
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;
  assign bus.break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: 8N1, 8E1 and 9N2 receivers on one clock.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1, rx2;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if2 ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .rx(rx0), .bus(if0.master));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .rx(rx1), .bus(if1.master));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2))
    u2 (.clk(clk), .rst(rst), .rx(rx2), .bus(if2.master));

  typedef struct {
    int         u;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_pass = 0;
  int vcyc0  = 0;
  int ovr0   = 0;
  int brk0   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input int u, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.u = u; e.d = d; e.pe = pe; e.fe = fe;
    sbq.push_back(e);
  endtask

  task automatic pop(input int u, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_unit", 32'(u), 32'(e.u));
      chk("data", 32'(d), 32'(e.d));
      chk("parity_err", 32'(pe), 32'(e.pe));
      chk("frame_err", 32'(fe), 32'(e.fe));
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (if0.valid === 1'b1) vcyc0++;
    if (if0.overrun === 1'b1) ovr0++;
    if (if0.break_det === 1'b1) brk0++;
    if (if0.valid === 1'b1 && if0.ready === 1'b1)
      pop(0, {1'b0, if0.data}, if0.parity_err, if0.frame_err);
    if (if1.valid === 1'b1 && if1.ready === 1'b1)
      pop(1, {1'b0, if1.data}, if1.parity_err, if1.frame_err);
    if (if2.valid === 1'b1 && if2.ready === 1'b1)
      pop(2, if2.data, if2.parity_err, if2.frame_err);
  end

  task automatic set_rx(input int u, input logic v);
    case (u)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic idle_bits(input int nbits);
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // pbit < 0 means no parity bit; gbit/goff flip one cycle of frame bit gbit
  task automatic send_frame(input int u, input logic [8:0] d, input int nb, input int pbit,
                            input int nstop, input logic [1:0] stops,
                            input int gbit, input int goff);
    logic [15:0] bits;
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    n       = 1;
    for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
    if (pbit >= 0) begin bits[n] = pbit[0]; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++) begin
        set_rx(u, (b == gbit && c == goff) ? ~bits[b] : bits[b]);
        @(negedge clk);
      end
    set_rx(u, 1'b1);
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while (sbq.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, oc, bc;
    logic [7:0] pat [4];
    logic [7:0] pd;
    int pb;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C; pat[3] = 8'h81;

    rst = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    if0.ready = 1'b1; if1.ready = 1'b1; if2.ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(if0.valid), 32'd0);
    chk("rst_data", 32'(if0.data), 32'd0);
    chk("rst_perr", 32'(if0.parity_err), 32'd0);
    chk("rst_ferr", 32'(if0.frame_err), 32'd0);
    chk("rst_overrun", 32'(if0.overrun), 32'd0);
    chk("rst_break", 32'(if0.break_det), 32'd0);
    chk("rst_data9", 32'(if2.data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_bits(1);

    // 8N1 basic word, single-cycle valid with ready held high
    vc = vcyc0;
    push(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 2'b11, -1, 0);
    wait_drain(60);
    repeat (5) @(negedge clk);
    chk("valid_width", 32'(vcyc0 - vc), 32'd1);

    // Back-to-back 8N1 patterns
    for (int i = 0; i < 4; i++) begin
      push(0, {1'b0, pat[i]}, 1'b0, 1'b0);
      send_frame(0, {1'b0, pat[i]}, 8, -1, 1, 2'b11, -1, 0);
    end
    wait_drain(60);

    // Even parity: expected error is XOR of data and parity bit
    for (int i = 0; i < 4; i++) begin
      pd = (i < 2) ? 8'h03 : (i == 2) ? 8'hA5 : 8'h80;
      pb = (i == 1) ? 0 : 1;
      push(1, {1'b0, pd}, (^pd) ^ pb[0], 1'b0);
      send_frame(1, {1'b0, pd}, 8, pb, 1, 2'b11, -1, 0);
    end
    wait_drain(60);

    // Overrun: second word dropped while the first is held
    oc = ovr0;
    if0.ready = 1'b0;
    push(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, -1, 1, 2'b11, -1, 0);
    send_frame(0, 9'h022, 8, -1, 1, 2'b11, -1, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("overrun_count", 32'(ovr0 - oc), 32'd1);
    chk("held_valid", 32'(if0.valid), 32'd1);
    chk("held_data", 32'(if0.data), 32'h11);
    @(negedge clk);
    if0.ready = 1'b1;
    @(negedge clk);
    #1;
    chk("valid_drop", 32'(if0.valid), 32'd0);
    wait_drain(10);

    // Frame error: stop bit low with non-zero data
    push(0, 9'h055, 1'b0, 1'b1);
    send_frame(0, 9'h055, 8, -1, 1, 2'b00, -1, 0);
    idle_bits(2);
    wait_drain(60);

    // Break: line low for 12 bit times
    vc = vcyc0; bc = brk0;
    rx0 = 1'b0;
    idle_bits(12);
    rx0 = 1'b1;
    idle_bits(3);
    chk("break_count", 32'(brk0 - bc), 32'd1);
    chk("break_no_valid", 32'(vcyc0 - vc), 32'd0);

    // Start glitch of 3 cycles, then a clean word must still decode
    vc = vcyc0;
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    idle_bits(3);
    chk("glitch_no_valid", 32'(vcyc0 - vc), 32'd0);
    push(0, 9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, -1, 1, 2'b11, -1, 0);
    wait_drain(60);

    // Single-cycle glitch near the middle of data bit 2 of 0x00
    push(0, 9'h000, 1'b0, 1'b0);
    send_frame(0, 9'h000, 8, -1, 1, 2'b11, 3, 6);
    wait_drain(60);

    // Reset during bit 4 of 0xFF; only the following 0x3C may appear
    rx0 = 1'b0;
    repeat (CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (4 * CPB + 8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(if0.valid), 32'd0);
    chk("midrst_data", 32'(if0.data), 32'd0);
    idle_bits(2);
    push(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, -1, 1, 2'b11, -1, 0);
    wait_drain(60);

    // 9 data bits, 2 stop bits, including a low second stop bit
    push(2, 9'h1AB, 1'b0, 1'b0);
    send_frame(2, 9'h1AB, 9, -1, 2, 2'b11, -1, 0);
    push(2, 9'h0FF, 1'b0, 1'b0);
    send_frame(2, 9'h0FF, 9, -1, 2, 2'b11, -1, 0);
    push(2, 9'h100, 1'b0, 1'b1);
    send_frame(2, 9'h100, 9, -1, 2, 2'b01, -1, 0);
    idle_bits(2);
    wait_drain(60);

    idle_bits(2);
    chk("sb_final_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
